// File: rtl/trigger_pulse_gen_if.sv
// Handshake bundle for the trigger pulse generator: request/abort/clear in,
// trigger line plus status out.
interface trigger_pulse_gen_if #(
    parameter int PEND_W = 3
);
    logic              iTrigger_req;
    logic              iAbort;
    logic              iClr_ovf;
    logic              oTrigger_out;
    logic              oBusy;
    logic              oDone;
    logic [PEND_W-1:0] oPending;
    logic              oOverflow;

    modport master (
        output iTrigger_req, iAbort, iClr_ovf,
        input  oTrigger_out, oBusy, oDone, oPending, oOverflow
    );

    modport slave (
        input  iTrigger_req, iAbort, iClr_ovf,
        output oTrigger_out, oBusy, oDone, oPending, oOverflow
    );
endinterface

// File: rtl/trigger_pulse_gen.sv
// Turns 1-cycle trigger requests into fixed-width pulses separated by a minimum
// idle gap, queueing requests that arrive while a pulse or gap is in progress.
module trigger_pulse_gen #(
    parameter int PULSE_WIDTH = 16,
    parameter int GAP_WIDTH   = 16,
    parameter int CNT_W       = 16,
    parameter int PEND_W      = 3,
    parameter bit IDLE_LEVEL  = 1'b1
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    trigger_pulse_gen_if.slave  trigIf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } stateT;

    localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_WIDTH - 1);
    localparam logic [PEND_W-1:0] PEND_MAX   = '1;

    stateT             state, stateNxt;
    logic [CNT_W-1:0]  cnt, cntNxt;
    logic [PEND_W-1:0] pending, pendingNxt;
    logic              overflow, overflowNxt;
    logic              doneNxt;
    logic              trigOut;
    logic              busy;
    logic              done;

    logic              launch;
    logic              direct;
    logic              queueReq;
    logic              drop;

    always_comb begin
        stateNxt = state;
        launch   = 1'b0;
        direct   = 1'b0;
        doneNxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (!trigIf.iAbort && (trigIf.iTrigger_req || pending != '0)) begin
                    stateNxt = ASSERT;
                    launch   = (pending != '0);
                    direct   = (pending == '0);
                end
            end
            ASSERT: begin
                // An abort still routes through GAP so the far end sees the full idle gap
                if (trigIf.iAbort) begin
                    stateNxt = GAP;
                end else if (cnt == PULSE_LAST) begin
                    stateNxt = GAP;
                    doneNxt  = 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    if (!trigIf.iAbort && pending != '0) begin
                        stateNxt = ASSERT;
                        launch   = 1'b1;
                    end else if (!trigIf.iAbort && trigIf.iTrigger_req) begin
                        stateNxt = ASSERT;
                        direct   = 1'b1;
                    end else begin
                        stateNxt = IDLE;
                    end
                end
            end
            default: stateNxt = IDLE;
        endcase

        cntNxt = (stateNxt != state || state == IDLE) ? '0 : cnt + CNT_W'(1);

        queueReq = trigIf.iTrigger_req && !direct && !trigIf.iAbort;
        drop     = queueReq && !launch && (pending == PEND_MAX);

        pendingNxt = pending;
        if (trigIf.iAbort) begin
            pendingNxt = '0;
        end else if (queueReq && !launch && !drop) begin
            pendingNxt = pending + PEND_W'(1);
        end else if (launch && !queueReq) begin
            pendingNxt = pending - PEND_W'(1);
        end

        // A drop in the same cycle as a clear must leave the flag set
        if (drop) begin
            overflowNxt = 1'b1;
        end else if (trigIf.iClr_ovf) begin
            overflowNxt = 1'b0;
        end else begin
            overflowNxt = overflow;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            trigOut  <= IDLE_LEVEL;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= stateNxt;
            cnt      <= cntNxt;
            pending  <= pendingNxt;
            overflow <= overflowNxt;
            trigOut  <= (stateNxt == ASSERT) ? ~IDLE_LEVEL : IDLE_LEVEL;
            busy     <= (stateNxt != IDLE);
            done     <= doneNxt;
        end
    end

    assign trigIf.oTrigger_out = trigOut;
    assign trigIf.oBusy        = busy;
    assign trigIf.oDone        = done;
    assign trigIf.oPending     = pending;
    assign trigIf.oOverflow    = overflow;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Directed bench for trigger_pulse_gen with PULSE_WIDTH=4, GAP_WIDTH=3, PEND_W=2,
// IDLE_LEVEL=1; expected values are written out per cycle.
module tb_trigger_pulse_gen;

    localparam int PULSE_WIDTH = 4;
    localparam int GAP_WIDTH   = 3;
    localparam int CNT_W       = 4;
    localparam int PEND_W      = 2;

    logic iCLK   = 1'b0;
    logic iRST_n = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    int   falls;
    logic prevOut;

    trigger_pulse_gen_if #(.PEND_W(PEND_W)) trigIf ();

    trigger_pulse_gen #(
        .PULSE_WIDTH (PULSE_WIDTH),
        .GAP_WIDTH   (GAP_WIDTH),
        .CNT_W       (CNT_W),
        .PEND_W      (PEND_W),
        .IDLE_LEVEL  (1'b1)
    ) dut (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .trigIf (trigIf.slave)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkVal(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    initial begin
        trigIf.iTrigger_req = 1'b0;
        trigIf.iAbort       = 1'b0;
        trigIf.iClr_ovf     = 1'b0;

        // Reset values
        #12;
        checkVal("rst out",  int'(trigIf.oTrigger_out), 1);
        checkVal("rst busy", int'(trigIf.oBusy), 0);
        checkVal("rst done", int'(trigIf.oDone), 0);
        checkVal("rst pend", int'(trigIf.oPending), 0);
        checkVal("rst ovf",  int'(trigIf.oOverflow), 0);
        @(negedge iCLK);
        iRST_n = 1'b1;
        tick();

        // Single request
        trigIf.iTrigger_req = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            trigIf.iTrigger_req = 1'b0;
            checkVal($sformatf("t1 out@%0d", i),  int'(trigIf.oTrigger_out), (i <= 4) ? 0 : 1);
            checkVal($sformatf("t1 done@%0d", i), int'(trigIf.oDone), (i == 5) ? 1 : 0);
            checkVal($sformatf("t1 busy@%0d", i), int'(trigIf.oBusy), (i <= 7) ? 1 : 0);
        end

        // Three back-to-back requests
        trigIf.iTrigger_req = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            tick();
            trigIf.iTrigger_req = (i < 3);
            checkVal($sformatf("t2 out@%0d", i), int'(trigIf.oTrigger_out),
                     ((i >= 1 && i <= 4) || (i >= 8 && i <= 11) || (i >= 15 && i <= 18)) ? 0 : 1);
            checkVal($sformatf("t2 pend@%0d", i), int'(trigIf.oPending),
                     (i == 2) ? 1 : (i >= 3 && i <= 7) ? 2 : (i >= 8 && i <= 14) ? 1 : 0);
            checkVal($sformatf("t2 done@%0d", i), int'(trigIf.oDone),
                     (i == 5 || i == 12 || i == 19) ? 1 : 0);
            checkVal($sformatf("t2 busy@%0d", i), int'(trigIf.oBusy), (i <= 21) ? 1 : 0);
        end
        checkVal("t2 ovf", int'(trigIf.oOverflow), 0);

        // Queue overflow, clear colliding with a drop, then a plain clear
        falls   = 0;
        prevOut = trigIf.oTrigger_out;
        trigIf.iTrigger_req = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            tick();
            trigIf.iTrigger_req = (i < 6);
            trigIf.iClr_ovf     = (i == 5 || i == 6);
            if (prevOut && !trigIf.oTrigger_out) falls++;
            prevOut = trigIf.oTrigger_out;
            if (i == 4) checkVal("t3 ovf@4", int'(trigIf.oOverflow), 0);
            if (i == 5) checkVal("t3 pend@5", int'(trigIf.oPending), 3);
            if (i == 5) checkVal("t3 ovf@5", int'(trigIf.oOverflow), 1);
            if (i == 6) checkVal("t3 ovf@6", int'(trigIf.oOverflow), 1);
            if (i == 6) checkVal("t3 pend@6", int'(trigIf.oPending), 3);
            if (i == 7) checkVal("t3 ovf@7", int'(trigIf.oOverflow), 0);
            if (i == 8) checkVal("t3 pend@8", int'(trigIf.oPending), 2);
        end
        checkVal("t3 pulses", falls, 4);
        checkVal("t3 busy end", int'(trigIf.oBusy), 0);
        checkVal("t3 pend end", int'(trigIf.oPending), 0);

        // Abort in the second ASSERT cycle with two queued
        trigIf.iTrigger_req = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            trigIf.iTrigger_req = (i >= 4 && i <= 6);
            trigIf.iAbort       = (i == 9);
            if (i == 7) checkVal("t4 pend@7", int'(trigIf.oPending), 3);
            if (i == 8 || i == 9) begin
                checkVal($sformatf("t4 pend@%0d", i), int'(trigIf.oPending), 2);
                checkVal($sformatf("t4 out@%0d", i), int'(trigIf.oTrigger_out), 0);
            end
            if (i >= 10) begin
                checkVal($sformatf("t4 out@%0d", i),  int'(trigIf.oTrigger_out), 1);
                checkVal($sformatf("t4 pend@%0d", i), int'(trigIf.oPending), 0);
                checkVal($sformatf("t4 done@%0d", i), int'(trigIf.oDone), 0);
                checkVal($sformatf("t4 busy@%0d", i), int'(trigIf.oBusy), (i <= 12) ? 1 : 0);
            end
        end

        // Asynchronous reset in the middle of a pulse
        trigIf.iTrigger_req = 1'b1;
        tick();
        tick();
        trigIf.iTrigger_req = 1'b0;
        checkVal("t5 out pre", int'(trigIf.oTrigger_out), 0);
        checkVal("t5 pend pre", int'(trigIf.oPending), 1);
        #2;
        iRST_n = 1'b0;
        #1;
        checkVal("t5 out rst",  int'(trigIf.oTrigger_out), 1);
        checkVal("t5 pend rst", int'(trigIf.oPending), 0);
        checkVal("t5 busy rst", int'(trigIf.oBusy), 0);
        @(negedge iCLK);
        iRST_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checkVal($sformatf("t5 out@%0d", i),  int'(trigIf.oTrigger_out), 1);
            checkVal($sformatf("t5 busy@%0d", i), int'(trigIf.oBusy), 0);
        end

        // Request in the last gap cycle restarts with no extra idle
        trigIf.iTrigger_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            trigIf.iTrigger_req = (i == 7);
            checkVal($sformatf("t6 out@%0d", i), int'(trigIf.oTrigger_out),
                     (i <= 4 || i >= 8) ? 0 : 1);
            if (i == 8) checkVal("t6 pend@8", int'(trigIf.oPending), 0);
            if (i == 8) checkVal("t6 busy@8", int'(trigIf.oBusy), 1);
        end

        // Abort while idle leaves the line alone
        for (int i = 1; i <= 8; i++) tick();
        trigIf.iAbort       = 1'b1;
        trigIf.iTrigger_req = 1'b1;
        tick();
        trigIf.iAbort       = 1'b0;
        trigIf.iTrigger_req = 1'b0;
        checkVal("t7 out", int'(trigIf.oTrigger_out), 1);
        checkVal("t7 busy", int'(trigIf.oBusy), 0);
        tick();
        checkVal("t7 out2", int'(trigIf.oTrigger_out), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
